// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table scanner: FSM states and row geometry.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int NUM_ROWS = 8;
  localparam int ROW_W    = 3;

endpackage

// File: rtl/truth_table_scanner_row_sequencer.sv
// Row sequencer: settle counter that paces each row plus the 3-bit row counter itself.
module row_sequencer
  import truth_table_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             drive,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic             sample_en,
  output logic             last_row
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CNT_W-1:0] settle_cnt_r;
  logic [ROW_W-1:0] row_r;

  assign row       = row_r;
  assign sample_en = drive && (settle_cnt_r == CNT_W'(SETTLE - 1));
  assign last_row  = (row_r == ROW_W'(NUM_ROWS - 1));

  // Settle count restarts each row; the row only moves when the FSM leaves SAMPLE.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      settle_cnt_r <= '0;
      row_r        <= '0;
    end else begin
      if (drive) begin
        settle_cnt_r <= sample_en ? '0 : settle_cnt_r + CNT_W'(1);
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end
      if (advance) begin
        row_r <= row_r + ROW_W'(1);
      end else begin
        row_r <= row_r;
      end
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps {x,y,z} through all eight rows, captures each function output into a minterm
// vector and flags any function whose vector differs from the golden value latched at start.
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int N_FUNCS = 5,
  parameter int SETTLE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_FUNCS*8-1:0] golden,
  input  logic [N_FUNCS-1:0]   s_in,
  output logic                 x,
  output logic                 y,
  output logic                 z,
  output logic                 busy,
  output logic                 done,
  output logic [N_FUNCS*8-1:0] table_out,
  output logic [N_FUNCS-1:0]   mismatch
);

  state_t               state_r;
  logic [N_FUNCS*8-1:0] golden_r;
  logic [N_FUNCS*8-1:0] table_nxt_s;
  logic [N_FUNCS-1:0]   mismatch_nxt_s;
  logic [ROW_W-1:0]     row_s;
  logic                 sample_en_s;
  logic                 last_row_s;
  logic                 accept_s;
  logic                 drive_s;
  logic                 advance_s;

  assign accept_s  = (state_r == IDLE) && start;
  assign drive_s   = (state_r == DRIVE);
  assign advance_s = (state_r == SAMPLE) && !last_row_s;

  row_sequencer #(.SETTLE(SETTLE)) u_row_sequencer (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept_s),
    .drive     (drive_s),
    .advance   (advance_s),
    .row       (row_s),
    .sample_en (sample_en_s),
    .last_row  (last_row_s)
  );

  // Next capture image includes the current row, so the compare on the last row sees all 8 bits.
  always_comb begin
    table_nxt_s    = table_out;
    mismatch_nxt_s = '0;
    for (int f = 0; f < N_FUNCS; f++) begin
      table_nxt_s[f*8 + int'(row_s)] = s_in[f];
    end
    for (int f = 0; f < N_FUNCS; f++) begin
      mismatch_nxt_s[f] = (table_nxt_s[f*8 +: 8] != golden_r[f*8 +: 8]);
    end
  end

  // Scan FSM with registered stimulus, status and capture outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      golden_r  <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      z         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      mismatch  <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            golden_r  <= golden;
            table_out <= '0;
            mismatch  <= '0;
            {x, y, z} <= 3'b000;
            busy      <= 1'b1;
            state_r   <= DRIVE;
          end else begin
            state_r <= IDLE;
          end
        end
        DRIVE: begin
          if (sample_en_s) begin
            state_r <= SAMPLE;
          end else begin
            state_r <= DRIVE;
          end
        end
        SAMPLE: begin
          table_out <= table_nxt_s;
          if (last_row_s) begin
            mismatch <= mismatch_nxt_s;
            done     <= 1'b1;
            state_r  <= FINISH;
          end else begin
            {x, y, z} <= row_s + 3'd1;
            state_r   <= DRIVE;
          end
        end
        FINISH: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: two scanner instances (SETTLE=1 and SETTLE=3) fed by truth-table models of functions A..E.
module tb_truth_table_scanner;
  import truth_table_pkg::*;

  localparam logic [39:0] G_PASS  = {8'hDC, 8'h54, 8'h51, 8'h08, 8'h70};
  localparam logic [39:0] G_FAULT = {8'hDC, 8'h54, 8'h50, 8'h08, 8'h70};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [39:0] golden = '0;
  logic [4:0]  s_in1, s_in3;
  logic        x1, y1, z1, busy1, done1;
  logic        x3, y3, z3, busy3, done3;
  logic [39:0] table1, table3;
  logic [4:0]  mm1, mm3;

  logic [7:0]  func_tt [5] = '{8'h70, 8'h08, 8'h51, 8'h54, 8'hDC};

  int          sel = 0;
  logic [2:0]  obs_xyz;
  logic        obs_busy, obs_done;
  logic [39:0] obs_table;
  logic [4:0]  obs_mm;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_scanner #(.N_FUNCS(5), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .golden(golden), .s_in(s_in1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .table_out(table1), .mismatch(mm1)
  );

  truth_table_scanner #(.N_FUNCS(5), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .golden(golden), .s_in(s_in3),
    .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3), .table_out(table3), .mismatch(mm3)
  );

  always_comb begin
    for (int f = 0; f < 5; f++) begin
      s_in1[f] = func_tt[f][{x1, y1, z1}];
      s_in3[f] = func_tt[f][{x3, y3, z3}];
    end
  end

  always_comb begin
    if (sel == 0) begin
      obs_xyz = {x1, y1, z1}; obs_busy = busy1; obs_done = done1; obs_table = table1; obs_mm = mm1;
    end else begin
      obs_xyz = {x3, y3, z3}; obs_busy = busy3; obs_done = done3; obs_table = table3; obs_mm = mm3;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One full scan; optionally pulses start again while row 3 is on the wires.
  task automatic run_scan(input int sel_i, input int settle, input logic [39:0] gold,
                          input logic [4:0] exp_mm, input bit poke, input string tag);
    int hold [8];
    int cyc, lat, dones, prev;
    bit order_ok, poked;
    for (int r = 0; r < 8; r++) hold[r] = 0;
    lat = -1; dones = 0; prev = 0; order_ok = 1'b1; poked = 1'b0;
    sel = sel_i;
    @(negedge clk);
    golden = gold;
    if (sel_i == 0) start1 = 1'b1; else start3 = 1'b1;
    for (cyc = 1; cyc <= 8*(settle+1) + 10; cyc++) begin
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      if (cyc == 1) golden = ~gold;
      if (obs_done) begin
        dones++;
        if (lat < 0) lat = cyc;
      end else if (obs_busy) begin
        hold[obs_xyz]++;
        if (int'(obs_xyz) < prev || int'(obs_xyz) > prev + 1) order_ok = 1'b0;
        prev = int'(obs_xyz);
        if (poke && !poked && obs_xyz == 3'd3) begin
          poked = 1'b1;
          if (sel_i == 0) start1 = 1'b1; else start3 = 1'b1;
        end
      end
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(8*(settle+1) + 1));
    check_val({tag, "_done_count"}, 64'(dones), 64'd1);
    for (int r = 0; r < 8; r++)
      check_val($sformatf("%s_hold_row%0d", tag, r), 64'(hold[r]), 64'(settle + 1));
    check_val({tag, "_row_order"}, {63'd0, order_ok}, 64'd1);
    check_val({tag, "_table"}, {24'd0, obs_table}, {24'd0, G_PASS});
    check_val({tag, "_mismatch"}, {59'd0, obs_mm}, {59'd0, exp_mm});
    check_val({tag, "_idle_busy"}, {63'd0, obs_busy}, 64'd0);
    check_val({tag, "_xyz_hold"}, {61'd0, obs_xyz}, 64'd7);
  endtask

  initial begin
    // Reset with start held high: nothing may begin.
    @(negedge clk);
    reset = 1'b1; start1 = 1'b1; start3 = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_xyz", {61'd0, x1, y1, z1}, 64'd0);
    check_val("rst_busy", {62'd0, busy1, busy3}, 64'd0);
    check_val("rst_done", {62'd0, done1, done3}, 64'd0);
    check_val("rst_table", {24'd0, table1}, 64'd0);
    check_val("rst_mismatch", {54'd0, mm1, mm3}, 64'd0);
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_no_scan", {62'd0, busy1, busy3}, 64'd0);

    run_scan(0, 1, G_PASS,  5'b00000, 1'b0, "pass");
    run_scan(0, 1, G_FAULT, 5'b00100, 1'b0, "fault");
    check_val("fault_f2_vector", {56'd0, table1[23:16]}, 64'h51);
    run_scan(0, 1, G_PASS,  5'b00000, 1'b1, "busy_start");

    // Reset landing in the SAMPLE cycle of row 3.
    sel = 0;
    @(negedge clk);
    golden = G_PASS; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) @(negedge clk);
    check_val("midrst_pre_row", {61'd0, x1, y1, z1}, 64'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("midrst_xyz", {61'd0, x1, y1, z1}, 64'd0);
    check_val("midrst_busy_done", {62'd0, busy1, done1}, 64'd0);
    check_val("midrst_table", {24'd0, table1}, 64'd0);
    check_val("midrst_mismatch", {59'd0, mm1}, 64'd0);
    repeat (2) @(negedge clk);
    check_val("midrst_idle", {63'd0, busy1}, 64'd0);
    run_scan(0, 1, G_PASS, 5'b00000, 1'b0, "after_rst");

    run_scan(1, 3, G_PASS, 5'b00000, 1'b0, "settle3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
